seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed 4-digit seven-segment display driver.
//   Generates the 2-bit digit select that drives the 4:1 nibble mux (its sw input).
//   Takes the selected 4-bit value back from that mux.
//   Decodes the value to hex segments and drives the active-low anode enables with per-slot blanking to suppress ghosting.
// PARAMETERS
//   PRESCALE  50000  clock cycles per digit slot (50 MHz -> 1 kHz/slot, 250 Hz frame); legal range >= 2
//   BLANK     500    cycles at start of each slot with all anodes off; legal range 0 <= BLANK < PRESCALE
//   CNT_W     16     prescale counter width; 2**CNT_W must be >= PRESCALE
// PORTS
//   clk         in   1  system clock
//   reset       in   1  synchronous, active-high reset
//   enable      in   1  1 = scanning runs; 0 = counter/select frozen, display dark
//   digit       in   4  nibble for current sel, combinational from mux (same cycle as sel)
//   dp_mask     in   4  decimal point request per digit, bit i = digit i (1 = lit)
//   blank_mask  in   4  per-digit blank, bit i = digit i (1 = digit i kept dark)
//   sel         out  2  digit index to mux select; registered
//   an          out  4  anode enables, active-low, an[i] = digit i
//   seg         out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp          out  1  decimal point, active-low
//   slot_tick   out  1  1-cycle pulse on the cycle sel advances
// BEHAVIOUR
//   Reset (sync, priority over enable):
//   - cnt=0, sel=0, an=4'b1111, seg=7'h7F, dp=1, slot_tick=0.
//   Prescaler (enable=1):
//   - cnt counts 0..PRESCALE-1 and wraps to 0.
//   - On the wrap edge: sel <= sel+1 (mod 4, 3->0 wrap), slot_tick=1 for that cycle.
//   - Otherwise slot_tick=0.
//   Scan order:
//   - 0,1,2,3,0,...
//   - Each slot lasts exactly PRESCALE cycles.
//   Output stage (registered, 1-cycle latency from cnt/sel/digit/masks):
//   - an <= (enable && cnt>=BLANK && !blank_mask[sel]) ? ~(4'b0001<<sel) : 4'b1111
//   - seg <= (an condition true) ? dec(digit) : 7'h7F
//   - dp <= (an condition true) ? ~dp_mask[sel] : 1
//   - Because of the 1-cycle latency, the first lit cycle of slot k is cycle BLANK+1 after sel becomes k.
//   - The last lit cycle of slot k is the first cycle of slot k+1's blanking (its BLANK-period count 0); this is harmless because digit is still captured for old sel.
//   - Correction: an/seg/dp are computed from the pre-update sel and cnt, so they are always self-consistent.
//   - BLANK=0: no dark gap; anodes switch directly between digits.
//   Hex decode dec(v), active-low {g..a}:
//   - 0=1000000, 1=1111001, 2=0100100, 3=0110000
//   - 4=0011001, 5=0010010, 6=0000010, 7=1111000
//   - 8=0000000, 9=0010000, A=0001000, b=0000011
//   - C=1000110, d=0100001, E=0000110, F=0001110
//   enable=0:
//   - cnt and sel hold their values; slot_tick=0.
//   - From the next edge: an=1111, seg=7F, dp=1.
//   - When re-enabled, counting resumes from the held cnt.
//   Simultaneous events:
//   - reset overrides enable and wrap.
//   - A mask change mid-slot takes effect on the next edge.
//   Mid-operation reset: all state returns to reset values on that edge; no partial slot is completed.
//   At most one bit of an is ever low.
// TESTING (bench PRESCALE=8, BLANK=2)
//   1. reset=1 for 2 clk -> sel=0, an=1111, seg=7F, dp=1, slot_tick=0.
//      Then release with enable=1 -> slot_tick high every 8th cycle; sel steps 0,1,2,3,0.
//   2. Mux model with digits {3,2,1,0}=4'h8,4'h5,4'hA,4'h1; blank_mask=0.
//      -> Per slot: an dark 2 cycles then low for 6.
//      -> seg values in order: 1111001 (digit0), 0001000, 0010010, 0000000.
//   3. Sweep digit 0..F in slot 0 -> seg matches the decode table for every value.
//      dp_mask=4'b0001 -> dp=0 only while an=1110.
//   4. blank_mask=4'b0100 -> an never 1011 over 3 full frames; other digits unchanged.
//   5. enable=0 mid-slot at cnt=5 for 10 cycles -> sel/cnt frozen, an=1111, slot_tick=0.
//      Re-enable -> slot resumes at cnt=5; wrap occurs 3 cycles later.
//   6. reset pulse while sel=2, cnt=6 -> next edge: sel=0, cnt=0, an=1111, seg=7F.
//      First lit digit is digit0 at cycle 3 after release.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed seven-segment scanner with per-slot anode blanking.
module seg7_scan_driver #(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 500,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] digit,
  input  logic [3:0] dp_mask,
  input  logic [3:0] blank_mask,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       slot_tick
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d, dec;
  logic dp_q, dp_d, tick_q, tick_d, wrap, lit;
  always_comb begin
    case (digit)
      4'h0: dec = 7'b1000000;
      4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;
      4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;
      4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;
      4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0010000;
      4'hA: dec = 7'b0001000;
      4'hB: dec = 7'b0000011;
      4'hC: dec = 7'b1000110;
      4'hD: dec = 7'b0100001;
      4'hE: dec = 7'b0000110;
      default: dec = 7'b0001110;
    endcase
  end
  // Outputs use the pre-update cnt/sel, so digit is always the one the mux shows for sel_q.
  always_comb begin
    wrap   = enable && (cnt_q == CNT_W'(PRESCALE - 1));
    cnt_d  = !enable ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
    sel_d  = wrap ? sel_q + 2'd1 : sel_q;
    tick_d = wrap;
    lit    = enable && (cnt_q >= CNT_W'(BLANK)) && !blank_mask[sel_q];
    an_d   = lit ? ~(4'b0001 << sel_q) : 4'b1111;
    seg_d  = lit ? dec : 7'h7F;
    dp_d   = lit ? ~dp_mask[sel_q] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sel_q  <= 2'd0;
      an_q   <= 4'b1111;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= tick_d;
    end
  end
  assign sel       = sel_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign slot_tick = tick_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized bench with an arithmetic scan model checked every cycle.
module tb_seg7_scan_driver;
  localparam int P = 8;
  localparam int B = 2;
  localparam logic [6:0] DEC [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic clk = 0, reset = 1, enable = 0;
  logic [3:0] dp_mask = 0, blank_mask = 0, digit;
  logic [3:0] digs [4];
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp, slot_tick;
  int vecs = 0, errs = 0;
  int m = 0;
  seg7_scan_driver #(.PRESCALE(P), .BLANK(B), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .digit(digit), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .sel(sel), .an(an), .seg(seg), .dp(dp), .slot_tick(slot_tick)
  );
  always #5 clk = ~clk;
  assign digit = digs[sel];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %0h exp %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: m counts enabled cycles since reset; cnt = m mod P, sel = (m / P) mod 4.
  always @(posedge clk) begin
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_tick, on;
    int c, s;
    c = m % P;
    s = (m / P) % 4;
    on = !reset && enable && c >= B && !blank_mask[s];
    e_an = on ? ~(4'b0001 << s) : 4'b1111;
    e_seg = on ? DEC[digs[s]] : 7'h7F;
    e_dp = on ? ~dp_mask[s] : 1'b1;
    e_tick = !reset && enable && c == P - 1;
    if (reset) m = 0;
    else if (enable) m = m + 1;
    #1;
    chk("sel", 32'(sel), 32'((m / P) % 4));
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("tick", 32'(slot_tick), 32'(e_tick));
    chk("one_hot_an", 32'($countones(~an) <= 1), 32'd1);
  end
  initial begin
    int k;
    digs[0] = 4'h1; digs[1] = 4'hA; digs[2] = 4'h5; digs[3] = 4'h8;
    repeat (2) @(negedge clk);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 1);
    chk("rst_tick", 32'(slot_tick), 0);
    reset = 0; enable = 1;
    repeat (3) @(negedge clk);
    chk("lit0_an", 32'(an), 32'b1110);
    chk("lit0_seg", 32'(seg), 32'b1111001);
    repeat (8) @(negedge clk);
    chk("lit1_an", 32'(an), 32'b1101);
    chk("lit1_seg", 32'(seg), 32'b0001000);
    repeat (21) @(negedge clk);
    dp_mask = 4'b0001;
    for (int i = 0; i < 96; i++) begin
      digs[0] = 4'(i);
      @(negedge clk);
      if (an == 4'b1110) chk("dp_lit", 32'(dp), 0);
    end
    digs[0] = 4'h1;
    blank_mask = 4'b0100;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      chk("blank2", 32'(an != 4'b1011), 1);
    end
    blank_mask = 0;
    k = 0;
    while (m % P != 5 && k < 20) begin @(negedge clk); k++; end
    chk("reach_cnt5", 32'(m % P), 5);
    enable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("frz_an", 32'(an), 32'hF);
      chk("frz_tick", 32'(slot_tick), 0);
    end
    enable = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!slot_tick && k < 20);
    chk("resume_wrap", 32'(k), 3);
    k = 0;
    while (m % 32 != 22 && k < 40) begin @(negedge clk); k++; end
    chk("reach_s2c6", 32'(sel), 2);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_sel", 32'(sel), 0);
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    reset = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (an != 4'b1110 && k < 20);
    chk("first_lit", 32'(k), 3);
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      enable = ($urandom_range(0, 7) != 0);
      dp_mask = 4'($urandom);
      if ($urandom_range(0, 9) == 0) blank_mask = 4'($urandom);
      for (int j = 0; j < 4; j++) digs[j] = 4'($urandom);
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
